// File: rtl/hbus_wb_bridge.sv
// Classic Wishbone slave to HyperBus controller bridge: one 32-bit access becomes two 16-bit beats.
// Strobe to ack takes at least 6 edges; the controller paces beats with hb_ready_i/hb_valid_i.
module hbus_wb_bridge #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          wb_adr_i,
   input  logic [31:0]          wb_dat_i,
   input  logic [3:0]           wb_sel_i,
   input  logic                 wb_we_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   output logic [31:0]          wb_dat_o,
   output logic                 wb_ack_o,
   output logic                 wb_err_o,
   output logic [31:0]          hb_adr_o,
   output logic [2*WIDTH-1:0]   hb_dat_o,
   output logic                 hb_reg_space_o,
   output logic                 hb_wrq_o,
   output logic                 hb_rrq_o,
   input  logic [2*WIDTH-1:0]   hb_dat_i,
   input  logic                 hb_ready_i,
   input  logic                 hb_valid_i,
   input  logic                 hb_busy_i,
   input  logic                 hb_error_i
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_WRITE, S_READ, S_RELEASE, S_DONE
   } state_t;

   state_t         state;
   logic [31:0]    dat_q;
   logic           we_q;
   logic           beat;
   logic [TW-1:0]  tmo_cnt;
   logic           err_q;
   logic           abort_q;

   // Byte address bit 0 has no meaning on a 16-bit-word bus.
   logic unused_adr0;
   assign unused_adr0 = wb_adr_i[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         dat_q          <= '0;
         we_q           <= 1'b0;
         beat           <= 1'b0;
         tmo_cnt        <= '0;
         err_q          <= 1'b0;
         abort_q        <= 1'b0;
         wb_dat_o       <= '0;
         wb_ack_o       <= 1'b0;
         wb_err_o       <= 1'b0;
         hb_adr_o       <= '0;
         hb_dat_o       <= '0;
         hb_reg_space_o <= 1'b0;
         hb_wrq_o       <= 1'b0;
         hb_rrq_o       <= 1'b0;
      end else begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         if (state != S_IDLE && state != S_DONE && !wb_cyc_i)
            abort_q <= 1'b1;

         if (hb_error_i && state inside {S_WAIT, S_WRITE, S_READ, S_RELEASE}) begin
            hb_wrq_o <= 1'b0;
            hb_rrq_o <= 1'b0;
            err_q    <= 1'b1;
            state    <= S_DONE;
         end else begin
            case (state)
               S_IDLE: begin
                  // The termination pulse is still visible here; don't re-accept the same strobe.
                  if (wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o) begin
                     dat_q          <= wb_dat_i;
                     we_q           <= wb_we_i;
                     hb_adr_o       <= {2'b00, wb_adr_i[30:1]};
                     hb_reg_space_o <= wb_adr_i[31];
                     abort_q        <= 1'b0;
                     err_q          <= (wb_sel_i != 4'hF);
                     state          <= (wb_sel_i != 4'hF) ? S_DONE : S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (!hb_busy_i) begin
                     beat <= 1'b0;
                     if (we_q) begin
                        hb_wrq_o <= 1'b1;
                        hb_dat_o <= dat_q[31:16];
                        state    <= S_WRITE;
                     end else begin
                        hb_rrq_o <= 1'b1;
                        tmo_cnt  <= TMO_LOAD;
                        wb_dat_o <= '0;
                        state    <= S_READ;
                     end
                  end
               end
               S_WRITE: begin
                  if (hb_ready_i) begin
                     if (beat) begin
                        hb_wrq_o <= 1'b0;
                        state    <= S_RELEASE;
                     end else begin
                        beat     <= 1'b1;
                        hb_dat_o <= dat_q[15:0];
                     end
                  end
               end
               S_READ: begin
                  if (hb_valid_i && beat) begin
                     wb_dat_o[15:0] <= hb_dat_i;
                     hb_rrq_o       <= 1'b0;
                     state          <= S_RELEASE;
                  end else if (tmo_cnt == '0) begin
                     hb_rrq_o <= 1'b0;
                     err_q    <= 1'b1;
                     state    <= S_RELEASE;
                  end else begin
                     tmo_cnt <= tmo_cnt - 1'b1;
                     if (hb_valid_i) begin
                        wb_dat_o[31:16] <= hb_dat_i;
                        beat            <= 1'b1;
                     end
                  end
               end
               S_RELEASE: begin
                  if (!hb_busy_i)
                     state <= S_DONE;
               end
               S_DONE: begin
                  if (!abort_q && wb_cyc_i) begin
                     wb_ack_o <= !err_q;
                     wb_err_o <= err_q;
                  end
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hbus_wb_bridge.sv
// Directed and randomized checks of hbus_wb_bridge against a transaction-level model.
module tb_hbus_wb_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
   logic [31:0] hb_adr_o;
   logic [15:0] hb_dat_o, hb_dat_i;
   logic        hb_reg_space_o, hb_wrq_o, hb_rrq_o;
   logic        hb_ready_i, hb_valid_i, hb_busy_i, hb_error_i;

   hbus_wb_bridge #(.WIDTH(8), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o),
      .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
      .hb_adr_o(hb_adr_o), .hb_dat_o(hb_dat_o), .hb_reg_space_o(hb_reg_space_o),
      .hb_wrq_o(hb_wrq_o), .hb_rrq_o(hb_rrq_o), .hb_dat_i(hb_dat_i),
      .hb_ready_i(hb_ready_i), .hb_valid_i(hb_valid_i), .hb_busy_i(hb_busy_i),
      .hb_error_i(hb_error_i)
   );

   int total = 0;
   int bad   = 0;
   int ack_cnt = 0, err_cnt = 0, both_cnt = 0;

   always @(posedge clk) begin
      if (wb_ack_o) ack_cnt++;
      if (wb_err_o) err_cnt++;
      if (wb_ack_o && wb_err_o) both_cnt++;
      if (hb_wrq_o && hb_rrq_o) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] map_adr(input logic [31:0] a);
      return {2'b00, a[30:1]};
   endfunction

   task automatic start_req(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic we);
      wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
   endtask

   task automatic end_req;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] adr, input logic [31:0] dat, input logic [31:0] exp_adr,
                           input bit rand_ready, input int rel_busy);
      int sent, n, a0, e0;
      logic [15:0] words [2];
      words[0] = dat[31:16];
      words[1] = dat[15:0];
      a0 = ack_cnt; e0 = err_cnt;
      hb_busy_i = 1'b0;
      start_req(adr, dat, 4'hF, 1'b1);
      tick;
      check("wr_wait_wrq", hb_wrq_o, 0);
      tick;
      check("wr_wrq", hb_wrq_o, 1);
      check("wr_adr", hb_adr_o, exp_adr);
      check("wr_space", hb_reg_space_o, adr[31]);
      hb_busy_i = 1'b1;
      sent = 0; n = 0;
      while (sent < 2 && n < 40) begin
         hb_ready_i = rand_ready ? ((n > 8) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
         check("wr_dat", hb_dat_o, words[sent]);
         check("wr_held", hb_wrq_o, 1);
         tick;
         if (hb_ready_i) sent++;
         n++;
      end
      hb_ready_i = 1'b0;
      check("wr_beats", sent, 2);
      check("wr_drop", hb_wrq_o, 0);
      repeat (rel_busy) begin
         tick;
         check("wr_rel_noack", wb_ack_o, 0);
      end
      hb_busy_i = 1'b0;
      tick;
      check("wr_done_noack", wb_ack_o, 0);
      tick;
      check("wr_ack", wb_ack_o, 1);
      check("wr_noerr", wb_err_o, 0);
      end_req;
      tick;
      check("wr_ack_pulse", wb_ack_o, 0);
      check("wr_ack_count", ack_cnt - a0, 1);
      check("wr_err_count", err_cnt - e0, 0);
   endtask

   task automatic do_read(input logic [31:0] adr, input logic [31:0] exp_adr,
                          input logic [15:0] hi, input logic [15:0] lo,
                          input int wait_busy, input int g0, input int g1);
      int a0, e0;
      a0 = ack_cnt; e0 = err_cnt;
      hb_busy_i = (wait_busy > 0);
      start_req(adr, $urandom, 4'hF, 1'b0);
      tick;
      repeat (wait_busy) begin
         tick;
         check("rd_wait_rrq", hb_rrq_o, 0);
      end
      hb_busy_i = 1'b0;
      tick;
      check("rd_rrq", hb_rrq_o, 1);
      check("rd_nowrq", hb_wrq_o, 0);
      check("rd_adr", hb_adr_o, exp_adr);
      check("rd_space", hb_reg_space_o, adr[31]);
      hb_busy_i = 1'b1;
      repeat (g0) begin
         tick;
         check("rd_held0", hb_rrq_o, 1);
      end
      hb_valid_i = 1'b1; hb_dat_i = hi;
      tick;
      hb_valid_i = 1'b0;
      check("rd_held1", hb_rrq_o, 1);
      repeat (g1) begin
         tick;
         check("rd_held2", hb_rrq_o, 1);
      end
      hb_valid_i = 1'b1; hb_dat_i = lo;
      tick;
      check("rd_drop", hb_rrq_o, 0);
      check("rd_data", wb_dat_o, {hi, lo});
      hb_dat_i = ~lo;
      tick;
      hb_valid_i = 1'b0;
      check("rd_extra_ignored", wb_dat_o, {hi, lo});
      hb_busy_i = 1'b0;
      tick;
      check("rd_done_noack", wb_ack_o, 0);
      tick;
      check("rd_ack", wb_ack_o, 1);
      check("rd_noerr", wb_err_o, 0);
      check("rd_data_at_ack", wb_dat_o, {hi, lo});
      end_req;
      tick;
      check("rd_ack_count", ack_cnt - a0, 1);
      check("rd_err_count", err_cnt - e0, 0);
   endtask

   initial begin
      int n, a0, e0;
      logic [31:0] radr, rdat;
      rst = 1'b1;
      wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      hb_dat_i = '0; hb_ready_i = 1'b0; hb_valid_i = 1'b0; hb_busy_i = 1'b0; hb_error_i = 1'b0;
      repeat (2) tick;
      check("rst_ack", wb_ack_o, 0);
      check("rst_err", wb_err_o, 0);
      check("rst_wrq", hb_wrq_o, 0);
      check("rst_rrq", hb_rrq_o, 0);
      check("rst_adr", hb_adr_o, 0);
      check("rst_dat", hb_dat_o, 0);
      check("rst_rdat", wb_dat_o, 0);
      check("rst_space", hb_reg_space_o, 0);
      rst = 1'b0;
      tick;

      // Directed write and reads with fixed expectations.
      do_write(32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0008, 1'b0, 0);
      do_write(32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0020, 1'b0, 3);
      do_read(32'h0000_0020, 32'h0000_0010, 16'h1234, 16'h5678, 0, 0, 0);
      do_read(32'h8000_0002, 32'h0000_0001, 16'hA5A5, 16'h5A5A, 2, 1, 2);

      // Read timeout: no valid beats at all.
      a0 = ack_cnt; e0 = err_cnt;
      hb_busy_i = 1'b0;
      start_req(32'h0000_0100, 32'h0, 4'hF, 1'b0);
      tick;
      tick;
      check("to_rrq", hb_rrq_o, 1);
      n = 0;
      while (n < 200) begin
         tick;
         n++;
         if (!hb_rrq_o) break;
      end
      check("to_cycles", n, 64);
      tick;
      check("to_done_noerr", wb_err_o, 0);
      tick;
      check("to_err", wb_err_o, 1);
      check("to_noack", wb_ack_o, 0);
      end_req;
      tick;
      check("to_err_count", err_cnt - e0, 1);
      check("to_ack_count", ack_cnt - a0, 0);

      // Partial byte select is rejected without touching the controller.
      a0 = ack_cnt; e0 = err_cnt;
      start_req(32'h0000_0200, 32'h1111_2222, 4'h3, 1'b1);
      tick;
      check("sel_nowrq1", hb_wrq_o, 0);
      check("sel_noerr_yet", wb_err_o, 0);
      tick;
      check("sel_err", wb_err_o, 1);
      check("sel_nowrq2", hb_wrq_o, 0);
      end_req;
      tick;
      check("sel_err_pulse", wb_err_o, 0);
      check("sel_err_count", err_cnt - e0, 1);
      check("sel_ack_count", ack_cnt - a0, 0);

      // Controller error during READ.
      a0 = ack_cnt; e0 = err_cnt;
      start_req(32'h0000_0300, 32'h0, 4'hF, 1'b0);
      tick;
      tick;
      tick;
      check("herr_rrq", hb_rrq_o, 1);
      hb_error_i = 1'b1;
      tick;
      hb_error_i = 1'b0;
      check("herr_rrq_drop", hb_rrq_o, 0);
      check("herr_wrq", hb_wrq_o, 0);
      tick;
      check("herr_err", wb_err_o, 1);
      check("herr_noack", wb_ack_o, 0);
      end_req;
      tick;
      check("herr_err_count", err_cnt - e0, 1);
      check("herr_ack_count", ack_cnt - a0, 0);

      // Reset during write beat 1.
      a0 = ack_cnt; e0 = err_cnt;
      start_req(32'h0000_0400, 32'h9876_5432, 4'hF, 1'b1);
      tick;
      tick;
      hb_ready_i = 1'b1;
      tick;
      check("rstw_beat1", hb_dat_o, 32'h0000_5432);
      rst = 1'b1;
      tick;
      check("rstw_wrq", hb_wrq_o, 0);
      check("rstw_dat", hb_dat_o, 0);
      check("rstw_adr", hb_adr_o, 0);
      check("rstw_ack", wb_ack_o, 0);
      check("rstw_err", wb_err_o, 0);
      rst = 1'b0; hb_ready_i = 1'b0;
      end_req;
      repeat (3) tick;
      check("rstw_ack_count", ack_cnt - a0, 0);
      check("rstw_err_count", err_cnt - e0, 0);
      do_write(32'h0000_0400, 32'h0BAD_F00D, 32'h0000_0200, 1'b0, 0);

      // Cycle dropped mid-read: HyperBus side finishes, no termination pulse.
      a0 = ack_cnt; e0 = err_cnt;
      start_req(32'h0000_0500, 32'h0, 4'hF, 1'b0);
      tick;
      tick;
      hb_busy_i = 1'b1;
      end_req;
      hb_valid_i = 1'b1; hb_dat_i = 16'h0F0F;
      tick;
      check("drop_rrq_held", hb_rrq_o, 1);
      hb_dat_i = 16'hF0F0;
      tick;
      hb_valid_i = 1'b0;
      check("drop_rrq", hb_rrq_o, 0);
      hb_busy_i = 1'b0;
      repeat (3) tick;
      check("drop_ack_count", ack_cnt - a0, 0);
      check("drop_err_count", err_cnt - e0, 0);

      // Randomized mix against the model.
      for (int i = 0; i < 8; i++) begin
         radr = $urandom;
         rdat = $urandom;
         if ($urandom_range(0, 1) == 1)
            do_write(radr, rdat, map_adr(radr), 1'b1, $urandom_range(0, 3));
         else
            do_read(radr, map_adr(radr), rdat[31:16], rdat[15:0],
                    $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      check("never_both", both_cnt, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
